lr_phase_sequencer: RTL and testbench
=====================================

# lr_phase_sequencer

Top-level phase controller for the linear-regression engine. It owns the shared sample memory's address counter and write strobe, and sequences the memory through four phases in order: load N samples from the input stream, stream them to the mean unit, the coefficient unit and the error unit. It issues one-cycle start pulses to each unit and waits on each unit's ready level before advancing. The mean, coefficient and error units and the sample memory are all slaves of this block.

## Interface
- N_SAMPLES, 150, number of (x, y) samples per run; must be ≥ 1.
- ADDR_W, 8, address/counter width; 2^ADDR_W ≥ N_SAMPLES is required.
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  run request; sampled only in IDLE.
- inValid  in  1  input sample present on the loader data bus; honoured only in LOAD.
- meanReady / calcReady / errReady  in  1 each  level "unit finished" from the mean, coefficient and error units.
- ready  out  1  high only in IDLE.
- addr  out  ADDR_W  sample memory address; equals the counter in LOAD and STREAM states, 0 otherwise.
- memWrite  out  1  memory write strobe.
- sampleValid  out  1  the memory read data at addr is a valid sample for the active unit.
- meanStart / calcStart / errStart  out  1 each  one-cycle start pulses.
- errDone  out  1  one-cycle run-complete pulse.
- phase  out  3  encoding: 0 IDLE, 1 LOAD, 2 MEAN, 3 CALC, 4 ERR, 5 DONE.

## Operation
- States:
  - IDLE, LOAD.
  - M_START, M_STREAM, M_WAIT.
  - C_START, C_STREAM, C_WAIT.
  - E_START, E_STREAM, E_WAIT.
  - DONE.
- State-to-phase mapping: the X_START, X_STREAM and X_WAIT states of each unit all report that unit's phase.
- IDLE:
  - ready=1; counter held at 0.
  - start=1 → LOAD. Otherwise stay in IDLE.
- LOAD:
  - memWrite = inValid (combinational); addr = counter.
  - Each cycle with inValid=1, the counter increments.
  - A write with counter = N_SAMPLES-1 → M_START, counter cleared.
  - A cycle with inValid=0 is a stall: no write, no increment.
- X_START (X = M/C/E):
  - The corresponding start output is 1 for exactly this cycle.
  - Counter is 0. Next state is X_STREAM unconditionally.
- X_STREAM:
  - sampleValid=1; addr = counter. The counter increments every cycle; there is no stall.
  - Counter = N_SAMPLES-1 → X_WAIT, counter cleared.
  - Memory read is asynchronous: data is valid in the same cycle as addr.
- X_WAIT:
  - Sample the corresponding ready signal. If 1, advance: M→C_START, C→E_START, E→DONE. If 0, hold.
- DONE: errDone=1 for one cycle, then IDLE.
- Ignored inputs:
  - The unit ready signals are ignored outside their own X_WAIT state, including when high during STREAM.
  - start is ignored outside IDLE.
  - inValid is ignored outside LOAD.
- Counter arithmetic: ADDR_W bits, terminal count N_SAMPLES-1, never wraps. Compare against N_SAMPLES-1 truncated to ADDR_W.
- N_SAMPLES=1: LOAD ends on the first valid write; each STREAM state lasts exactly one cycle.
- Outputs not listed for a state are 0.

## Timing
- Reset: on any rising edge with rst=1, the state goes to IDLE and the counter to 0, including mid-run. After that edge:
  - ready=1, phase=0.
  - addr=0, memWrite=0, sampleValid=0.
  - All start outputs and errDone are 0.
- rst overrides start in the same cycle.
- Latency, with start sampled at edge 0, inValid held high and every ready already high on entry to its WAIT state:
  - LOAD: cycles 1..N.
  - M_START: cycle N+1; M_STREAM: N+2..2N+1; M_WAIT: 2N+2.
  - C_START: 2N+3; C_STREAM: 2N+4..3N+3; C_WAIT: 3N+4.
  - E_START: 3N+5; E_STREAM: 3N+6..4N+5; E_WAIT: 3N+6+N.
  - DONE (errDone=1): cycle 4N+7. ready=1 again at cycle 4N+8.
- Each start pulse precedes the first sampleValid of its phase by exactly one cycle.
- Each WAIT state lasts at least 1 cycle. Every LOAD stall cycle or cycle of ready low adds exactly one cycle to the total.
- A start held high through DONE launches a new run only on the first IDLE cycle, i.e. LOAD begins at cycle 4N+9.

## Test plan
- Nominal run, N_SAMPLES=4, inValid and all readies held high, start pulsed at cycle 0:
  - memWrite at addr 0,1,2,3 in cycles 1–4.
  - meanStart at 5, calcStart at 11, errStart at 17.
  - errDone at 23 only; ready=1 at 24.
- LOAD stalls: inValid pattern 1,0,0,1,1,0,1:
  - Exactly 4 writes at addr 0–3, no address skipped.
  - M_START 3 cycles later than nominal.
- Unit back-pressure: meanReady low until 5 cycles into M_WAIT → calcStart delayed by exactly 5 cycles.
  - meanReady pulsed high during M_STREAM → no early advance.
- Reset mid-run: rst asserted during the second C_STREAM cycle:
  - Next cycle phase=0, ready=1, addr=0, all strobes 0.
  - A new start reruns from LOAD with addr 0.
- N_SAMPLES=1 boundary: one write, then each STREAM state is 1 cycle with addr=0; errDone at cycle 11.
- Ignored inputs: start toggled throughout a run and inValid toggled outside LOAD → no extra writes, no restarts, cycle timeline identical to nominal.

Source files
------------

// File: rtl/lr_phase_sequencer.sv
// Phase controller for the linear-regression engine.
// Owns the shared sample-memory address counter and write strobe. It walks
// LOAD -> MEAN -> CALC -> ERR -> DONE, issues one-cycle start pulses to each
// unit, and waits on each unit's ready level before moving to the next phase.
//
// Handshake contract: i_in_valid is a valid-only strobe with no back-pressure.
// In LOAD, every cycle with i_in_valid=1 writes exactly one sample at o_addr
// and advances the counter; cycles with i_in_valid=0 are stalls. In the
// STREAM states o_sample_valid=1 on every cycle and the memory read is
// asynchronous, so o_addr and the read data line up in the same cycle.
// The unit ready inputs are levels and are only looked at in that unit's
// own WAIT state.
module lr_phase_sequencer #(
  parameter int N_SAMPLES = 150,
  parameter int ADDR_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic              i_in_valid,
  input  logic              i_mean_ready,
  input  logic              i_calc_ready,
  input  logic              i_err_ready,
  output logic              o_ready,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_mem_write,
  output logic              o_sample_valid,
  output logic              o_mean_start,
  output logic              o_calc_start,
  output logic              o_err_start,
  output logic              o_err_done,
  output logic [2:0]        o_phase,
  output logic [3:0]        o_dbg_state
);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_LOAD     = 4'd1,
    S_M_START  = 4'd2,
    S_M_STREAM = 4'd3,
    S_M_WAIT   = 4'd4,
    S_C_START  = 4'd5,
    S_C_STREAM = 4'd6,
    S_C_WAIT   = 4'd7,
    S_E_START  = 4'd8,
    S_E_STREAM = 4'd9,
    S_E_WAIT   = 4'd10,
    S_DONE     = 4'd11
  } state_t;

  localparam logic [2:0] PH_IDLE = 3'd0;
  localparam logic [2:0] PH_LOAD = 3'd1;
  localparam logic [2:0] PH_MEAN = 3'd2;
  localparam logic [2:0] PH_CALC = 3'd3;
  localparam logic [2:0] PH_ERR  = 3'd4;
  localparam logic [2:0] PH_DONE = 3'd5;

  // Terminal count, truncated to the counter width.
  localparam logic [ADDR_W-1:0] LP_LAST = ADDR_W'(N_SAMPLES - 1);

  state_t            r_state;
  logic [ADDR_W-1:0] r_cnt;
  logic              r_ready;
  logic              r_load;
  logic              r_sample_valid;
  logic              r_mean_start;
  logic              r_calc_start;
  logic              r_err_start;
  logic              r_err_done;
  logic [2:0]        r_phase;

  state_t            w_state_nxt;
  logic [ADDR_W-1:0] w_cnt_nxt;
  logic              w_last;
  logic [2:0]        w_phase_nxt;

  assign w_last = (r_cnt == LP_LAST);

  // Next-state and next-counter selection.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        if (i_start) w_state_nxt = S_LOAD;
      end
      S_LOAD: begin
        if (i_in_valid) begin
          if (w_last) begin
            w_state_nxt = S_M_START;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
      end
      S_M_START: begin
        w_cnt_nxt   = '0;
        w_state_nxt = S_M_STREAM;
      end
      S_M_STREAM: begin
        if (w_last) begin
          w_state_nxt = S_M_WAIT;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_M_WAIT: begin
        if (i_mean_ready) w_state_nxt = S_C_START;
      end
      S_C_START: begin
        w_cnt_nxt   = '0;
        w_state_nxt = S_C_STREAM;
      end
      S_C_STREAM: begin
        if (w_last) begin
          w_state_nxt = S_C_WAIT;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_C_WAIT: begin
        if (i_calc_ready) w_state_nxt = S_E_START;
      end
      S_E_START: begin
        w_cnt_nxt   = '0;
        w_state_nxt = S_E_STREAM;
      end
      S_E_STREAM: begin
        if (w_last) begin
          w_state_nxt = S_E_WAIT;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_E_WAIT: begin
        if (i_err_ready) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        w_cnt_nxt   = '0;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_cnt_nxt   = '0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Phase number reported for the state being entered.
  always_comb begin
    w_phase_nxt = PH_IDLE;
    case (w_state_nxt)
      S_LOAD:                           w_phase_nxt = PH_LOAD;
      S_M_START, S_M_STREAM, S_M_WAIT:  w_phase_nxt = PH_MEAN;
      S_C_START, S_C_STREAM, S_C_WAIT:  w_phase_nxt = PH_CALC;
      S_E_START, S_E_STREAM, S_E_WAIT:  w_phase_nxt = PH_ERR;
      S_DONE:                           w_phase_nxt = PH_DONE;
      default:                          w_phase_nxt = PH_IDLE;
    endcase
  end

  // State, counter and registered per-state outputs (decoded from next state).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_cnt          <= '0;
      r_ready        <= 1'b1;
      r_load         <= 1'b0;
      r_sample_valid <= 1'b0;
      r_mean_start   <= 1'b0;
      r_calc_start   <= 1'b0;
      r_err_start    <= 1'b0;
      r_err_done     <= 1'b0;
      r_phase        <= PH_IDLE;
    end else begin
      r_state        <= w_state_nxt;
      r_cnt          <= w_cnt_nxt;
      r_ready        <= (w_state_nxt == S_IDLE);
      r_load         <= (w_state_nxt == S_LOAD);
      r_sample_valid <= (w_state_nxt == S_M_STREAM) ||
                        (w_state_nxt == S_C_STREAM) ||
                        (w_state_nxt == S_E_STREAM);
      r_mean_start   <= (w_state_nxt == S_M_START);
      r_calc_start   <= (w_state_nxt == S_C_START);
      r_err_start    <= (w_state_nxt == S_E_START);
      r_err_done     <= (w_state_nxt == S_DONE);
      r_phase        <= w_phase_nxt;
    end
  end

  // The write strobe follows the input valid combinationally while loading;
  // the address is only driven in LOAD and STREAM.
  assign o_mem_write    = r_load & i_in_valid;
  assign o_addr         = (r_load | r_sample_valid) ? r_cnt : '0;
  assign o_ready        = r_ready;
  assign o_sample_valid = r_sample_valid;
  assign o_mean_start   = r_mean_start;
  assign o_calc_start   = r_calc_start;
  assign o_err_start    = r_err_start;
  assign o_err_done     = r_err_done;
  assign o_phase        = r_phase;
  assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_lr_phase_sequencer.sv
// Bench for lr_phase_sequencer: two instances (N=4 and N=1) share stimulus.
// Each row of the vector table is one clock cycle: inputs for that cycle and
// the outputs expected during it. Rows are built from the phase timeline.
module tb_lr_phase_sequencer;

  logic clk;
  logic rst;
  logic i_start;
  logic i_in_valid;
  logic i_mean_ready;
  logic i_calc_ready;
  logic i_err_ready;

  logic       o4_ready, o4_mem_write, o4_sample_valid;
  logic       o4_mean_start, o4_calc_start, o4_err_start, o4_err_done;
  logic [7:0] o4_addr;
  logic [2:0] o4_phase;
  logic [3:0] o4_dbg_state;

  logic       o1_ready, o1_mem_write, o1_sample_valid;
  logic       o1_mean_start, o1_calc_start, o1_err_start, o1_err_done;
  logic [7:0] o1_addr;
  logic [2:0] o1_phase;
  logic [3:0] o1_dbg_state;

  lr_phase_sequencer #(.N_SAMPLES(4), .ADDR_W(8)) dut4 (
    .clk(clk), .rst(rst), .i_start(i_start), .i_in_valid(i_in_valid),
    .i_mean_ready(i_mean_ready), .i_calc_ready(i_calc_ready), .i_err_ready(i_err_ready),
    .o_ready(o4_ready), .o_addr(o4_addr), .o_mem_write(o4_mem_write),
    .o_sample_valid(o4_sample_valid), .o_mean_start(o4_mean_start),
    .o_calc_start(o4_calc_start), .o_err_start(o4_err_start),
    .o_err_done(o4_err_done), .o_phase(o4_phase), .o_dbg_state(o4_dbg_state)
  );

  lr_phase_sequencer #(.N_SAMPLES(1), .ADDR_W(8)) dut1 (
    .clk(clk), .rst(rst), .i_start(i_start), .i_in_valid(i_in_valid),
    .i_mean_ready(i_mean_ready), .i_calc_ready(i_calc_ready), .i_err_ready(i_err_ready),
    .o_ready(o1_ready), .o_addr(o1_addr), .o_mem_write(o1_mem_write),
    .o_sample_valid(o1_sample_valid), .o_mean_start(o1_mean_start),
    .o_calc_start(o1_calc_start), .o_err_start(o1_err_start),
    .o_err_done(o1_err_done), .o_phase(o1_phase), .o_dbg_state(o1_dbg_state)
  );

  // Output vector: {ready, mem_write, sample_valid, mean_start, calc_start,
  //                 err_start, err_done, phase[2:0], addr[7:0]}
  logic [17:0] w_out4;
  logic [17:0] w_out1;
  assign w_out4 = {o4_ready, o4_mem_write, o4_sample_valid, o4_mean_start,
                   o4_calc_start, o4_err_start, o4_err_done, o4_phase, o4_addr};
  assign w_out1 = {o1_ready, o1_mem_write, o1_sample_valid, o1_mean_start,
                   o1_calc_start, o1_err_start, o1_err_done, o1_phase, o1_addr};

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  // ---------------- vector table ----------------
  typedef struct {
    logic        rst;
    logic        start;
    logic        in_valid;
    logic        mr;
    logic        cr;
    logic        er;
    logic        chk;
    logic        use1;
    logic [17:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   seg_lo[9];
  int   seg_hi[9];

  int   g_row;
  int   g_cut;
  logic g_tog;
  logic g_use1;

  // ---------------- scoreboard state ----------------
  logic [17:0] exp_q[$];
  int          row_q[$];
  int          checks;
  int          failures;
  int          cur_rel;
  logic        cur_use1;
  int          ev_ms, ev_cs, ev_es, ev_ed, ev_rdy, ev_wr;

  function automatic logic [17:0] pk(input logic [6:0] f, input logic [2:0] ph,
                                     input logic [7:0] a);
    return {f, ph, a};
  endfunction

  // Background level for ignored inputs: steady high, or toggling per row.
  function automatic logic bg();
    return g_tog ? g_row[0] : 1'b1;
  endfunction

  function automatic logic st();
    return g_tog ? g_row[0] : 1'b0;
  endfunction

  task automatic add_raw(input logic r, input logic s, input logic chk,
                         input logic use1, input logic [17:0] e);
    vec_t v;
    v.rst = r; v.start = s; v.in_valid = 1'b0;
    v.mr = 1'b0; v.cr = 1'b0; v.er = 1'b0;
    v.chk = chk; v.use1 = use1; v.exp = e;
    vecs.push_back(v);
  endtask

  task automatic emit(input logic s, input logic iv, input logic mr, input logic cr,
                      input logic er, input logic [17:0] e);
    vec_t v;
    if (g_cut < 0 || g_row <= g_cut) begin
      v.rst = (g_row == g_cut);
      v.start = s; v.in_valid = iv;
      v.mr = mr; v.cr = cr; v.er = er;
      v.chk = 1'b1; v.use1 = g_use1; v.exp = e;
      vecs.push_back(v);
    end
    g_row++;
  endtask

  // One full run laid out along the phase timeline. Row 0 is the IDLE cycle
  // in which start is driven, so row k is cycle k of the run.
  task automatic build_run(input int n, input logic [15:0] pat, input int plen,
                           input int wm, input int wc, input int we,
                           input logic tog, input int cut, input logic use1);
    int cnt;
    int i;
    int w;
    logic iv;
    logic lst;
    logic [2:0] ph;
    g_row = 0; g_cut = cut; g_tog = tog; g_use1 = use1;
    emit(1'b1, bg(), bg(), bg(), bg(), pk(7'b1000000, 3'd0, 8'd0));
    cnt = 0;
    i = 0;
    while (cnt < n) begin
      iv = (i < plen) ? pat[i] : 1'b1;
      emit(st(), iv, bg(), bg(), bg(), pk({1'b0, iv, 5'b00000}, 3'd1, 8'(cnt)));
      cnt += int'(iv);
      i++;
    end
    for (int u = 0; u < 3; u++) begin
      ph = 3'(u + 2);
      w = (u == 0) ? wm : (u == 1) ? wc : we;
      emit(st(), bg(), bg(), bg(), bg(),
           pk({3'b000, (u == 0), (u == 1), (u == 2), 1'b0}, ph, 8'd0));
      for (int j = 0; j < n; j++)
        emit(st(), bg(), bg(), bg(), bg(), pk(7'b0010000, ph, 8'(j)));
      for (int k = 0; k < w; k++) begin
        lst = (k == w - 1);
        emit(st(), bg(),
             (u == 0) ? lst : bg(), (u == 1) ? lst : bg(), (u == 2) ? lst : bg(),
             pk(7'b0000000, ph, 8'd0));
      end
    end
    emit(st(), bg(), bg(), bg(), bg(), pk(7'b0000001, 3'd5, 8'd0));
    emit(1'b0, bg(), bg(), bg(), bg(), pk(7'b1000000, 3'd0, 8'd0));
  endtask

  // ---------------- driver ----------------
  task automatic apply_seg(input int lo, input int hi);
    ev_ms = -1; ev_cs = -1; ev_es = -1; ev_ed = -1; ev_rdy = -1; ev_wr = 0;
    for (int r = lo; r < hi; r++) begin
      @(posedge clk);
      #1;
      rst          = vecs[r].rst;
      i_start      = vecs[r].start;
      i_in_valid   = vecs[r].in_valid;
      i_mean_ready = vecs[r].mr;
      i_calc_ready = vecs[r].cr;
      i_err_ready  = vecs[r].er;
      cur_rel      = r - lo;
      cur_use1     = vecs[r].use1;
      if (vecs[r].chk) begin
        exp_q.push_back(vecs[r].exp);
        row_q.push_back(r);
      end
    end
    @(negedge clk);
    #1;
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", name, got, exp);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [17:0] got;
    logic [17:0] e;
    int          r;
    got = cur_use1 ? w_out1 : w_out4;
    if (got[16] === 1'b1) ev_wr++;
    if (got[14] === 1'b1 && ev_ms < 0) ev_ms = cur_rel;
    if (got[13] === 1'b1 && ev_cs < 0) ev_cs = cur_rel;
    if (got[12] === 1'b1 && ev_es < 0) ev_es = cur_rel;
    if (got[11] === 1'b1 && ev_ed < 0) ev_ed = cur_rel;
    if (got[17] === 1'b1 && cur_rel > 0 && ev_rdy < 0) ev_rdy = cur_rel;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      r = row_q.pop_front();
      checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL vec row=%0d got=%h expected=%h", r, got, e);
      end
    end
  end

  // ---------------- test ----------------
  initial begin
    checks = 0; failures = 0; cur_rel = 0; cur_use1 = 1'b0;
    rst = 1'b1; i_start = 1'b0; i_in_valid = 1'b0;
    i_mean_ready = 1'b0; i_calc_ready = 1'b0; i_err_ready = 1'b0;

    // s0: reset, then reset together with start must still leave IDLE
    seg_lo[0] = vecs.size();
    add_raw(1'b1, 1'b0, 1'b0, 1'b0, 18'd0);
    add_raw(1'b1, 1'b0, 1'b0, 1'b0, 18'd0);
    add_raw(1'b1, 1'b1, 1'b0, 1'b0, 18'd0);
    add_raw(1'b0, 1'b0, 1'b1, 1'b0, pk(7'b1000000, 3'd0, 8'd0));
    add_raw(1'b0, 1'b0, 1'b1, 1'b0, pk(7'b1000000, 3'd0, 8'd0));
    seg_hi[0] = vecs.size();
    // s1: nominal N=4
    seg_lo[1] = vecs.size();
    build_run(4, 16'h0000, 0, 1, 1, 1, 1'b0, -1, 1'b0);
    seg_hi[1] = vecs.size();
    // s2: LOAD stalls, inValid 1,0,0,1,1,0,1 (bit 0 first)
    seg_lo[2] = vecs.size();
    build_run(4, 16'b1011001, 7, 1, 1, 1, 1'b0, -1, 1'b0);
    seg_hi[2] = vecs.size();
    // s3: meanReady low for the first 5 M_WAIT cycles, high during M_STREAM
    seg_lo[3] = vecs.size();
    build_run(4, 16'h0000, 0, 6, 1, 1, 1'b0, -1, 1'b0);
    seg_hi[3] = vecs.size();
    // s4: start / inValid / other readies toggling where they must be ignored
    seg_lo[4] = vecs.size();
    build_run(4, 16'h0000, 0, 1, 1, 1, 1'b1, -1, 1'b0);
    seg_hi[4] = vecs.size();
    // s5: reset on the second C_STREAM cycle (cycle 13)
    seg_lo[5] = vecs.size();
    build_run(4, 16'h0000, 0, 1, 1, 1, 1'b0, 13, 1'b0);
    seg_hi[5] = vecs.size();
    // s6: fresh run straight after that reset
    seg_lo[6] = vecs.size();
    build_run(4, 16'h0000, 0, 1, 1, 1, 1'b0, -1, 1'b0);
    seg_hi[6] = vecs.size();
    // s7: reset, observed on the N=1 instance
    seg_lo[7] = vecs.size();
    add_raw(1'b1, 1'b0, 1'b0, 1'b1, 18'd0);
    add_raw(1'b0, 1'b0, 1'b1, 1'b1, pk(7'b1000000, 3'd0, 8'd0));
    seg_hi[7] = vecs.size();
    // s8: N=1 boundary run
    seg_lo[8] = vecs.size();
    build_run(1, 16'h0000, 0, 1, 1, 1, 1'b0, -1, 1'b1);
    seg_hi[8] = vecs.size();

    apply_seg(seg_lo[0], seg_hi[0]);

    apply_seg(seg_lo[1], seg_hi[1]);
    check_int("nom_mean_start", ev_ms, 5);
    check_int("nom_calc_start", ev_cs, 11);
    check_int("nom_err_start", ev_es, 17);
    check_int("nom_err_done", ev_ed, 23);
    check_int("nom_ready_back", ev_rdy, 24);
    check_int("nom_writes", ev_wr, 4);

    apply_seg(seg_lo[2], seg_hi[2]);
    check_int("stall_mean_start", ev_ms, 8);
    check_int("stall_err_done", ev_ed, 26);
    check_int("stall_writes", ev_wr, 4);

    apply_seg(seg_lo[3], seg_hi[3]);
    check_int("bp_mean_start", ev_ms, 5);
    check_int("bp_calc_start", ev_cs, 16);
    check_int("bp_err_done", ev_ed, 28);

    apply_seg(seg_lo[4], seg_hi[4]);
    check_int("tog_mean_start", ev_ms, 5);
    check_int("tog_calc_start", ev_cs, 11);
    check_int("tog_err_start", ev_es, 17);
    check_int("tog_err_done", ev_ed, 23);
    check_int("tog_ready_back", ev_rdy, 24);
    check_int("tog_writes", ev_wr, 4);

    apply_seg(seg_lo[5], seg_hi[5]);

    apply_seg(seg_lo[6], seg_hi[6]);
    check_int("rerun_mean_start", ev_ms, 5);
    check_int("rerun_err_done", ev_ed, 23);
    check_int("rerun_writes", ev_wr, 4);

    apply_seg(seg_lo[7], seg_hi[7]);

    apply_seg(seg_lo[8], seg_hi[8]);
    check_int("n1_mean_start", ev_ms, 2);
    check_int("n1_calc_start", ev_cs, 5);
    check_int("n1_err_start", ev_es, 8);
    check_int("n1_err_done", ev_ed, 11);
    check_int("n1_writes", ev_wr, 1);

    check_int("scoreboard_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
